// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit owning the HI/LO registers
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] work_hi, work_lo, opnd;
    logic             is_mul, neg_hi, neg_lo;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    logic             issue, issue_md, signed_op, div_zero, a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign issue     = start && !flush && (state == IDLE);
    assign issue_md  = issue && !op[2];
    assign signed_op = !op[0];
    // A signed divide by zero must hand back the raw dividend, so skip the abs/sign path.
    assign div_zero  = op[1] && (srcB == '0);
    assign a_neg     = signed_op && srcA[WIDTH-1] && !div_zero;
    assign b_neg     = signed_op && srcB[WIDTH-1];
    assign abs_a     = a_neg ? -srcA : srcA;
    assign abs_b     = b_neg ? -srcB : srcB;

    assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {work_hi, work_lo[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b0, opnd};
    assign prod_neg  = -{work_hi, work_lo};

    always_comb begin
        res_hi = work_hi;
        res_lo = work_lo;
        if (is_mul) begin
            if (neg_lo) begin
                res_hi = prod_neg[2*WIDTH-1:WIDTH];
                res_lo = prod_neg[WIDTH-1:0];
            end
        end else begin
            if (neg_hi) res_hi = -work_hi;
            if (neg_lo) res_lo = -work_lo;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue_md) state_nxt = RUN;
            RUN:     if (flush) state_nxt = IDLE;
                     else if (count == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            work_hi <= '0;
            work_lo <= '0;
            opnd    <= '0;
            is_mul  <= 1'b0;
            neg_hi  <= 1'b0;
            neg_lo  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == FIX) && !flush;
            case (state)
                IDLE: begin
                    if (issue_md) begin
                        count   <= CW'(WIDTH - 1);
                        work_hi <= '0;
                        is_mul  <= !op[1];
                        neg_lo  <= a_neg ^ b_neg;
                        neg_hi  <= op[1] ? a_neg : (a_neg ^ b_neg);
                        work_lo <= op[1] ? abs_a : abs_b;
                        opnd    <= op[1] ? abs_b : abs_a;
                    end else if (issue && op == 3'b100) begin
                        hi_q <= srcA;
                    end else if (issue && op == 3'b101) begin
                        lo_q <= srcA;
                    end
                end
                RUN: begin
                    count <= count - 1'b1;
                    if (is_mul) begin
                        // Product accumulates in work_hi while the multiplier shifts out of work_lo.
                        work_hi <= mul_sum[WIDTH:1];
                        work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
                    end else if (!div_diff[WIDTH+1]) begin
                        work_hi <= div_diff[WIDTH-1:0];
                        work_lo <= {work_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        work_hi <= div_shift[WIDTH-1:0];
                        work_lo <= {work_lo[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b0;
    logic [31:0] srcA = '0, srcB = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] hi_m = '0, lo_m = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .flush(flush), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        longint la, lb, q, r;
        logic [63:0] p;
        eh = hi_m;
        el = lo_m;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        case (o)
            3'd0: begin p = la * lb; eh = p[63:32]; el = p[31:0]; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    eh = a;
                    el = '1;
                end else if (o == 3'd2) begin
                    q = la / lb;
                    r = la % lb;
                    eh = r[31:0];
                    el = q[31:0];
                end else begin
                    eh = a % b;
                    el = a / b;
                end
            end
            3'd4: eh = a;
            3'd5: el = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [31:0] eh, el;
        model(o, a, b, eh, el);
        @(negedge clk);
        start = 1'b1; op = o; srcA = a; srcB = b;
        @(negedge clk);
        start = 1'b0;
        if (o[2]) begin
            hi_m = eh; lo_m = el;
            check("mt_busy", busy, 0);
            check("mt_done", done, 0);
        end else begin
            n = 0;
            while (busy && n < 100) begin
                if (done) check("busy_done_overlap", done, 0);
                n++;
                @(negedge clk);
            end
            check("latency", n, 33);
            check("done", done, 1);
            hi_m = eh; lo_m = el;
        end
        check("hi", HI, hi_m);
        check("lo", LO, lo_m);
        if (!o[2]) begin
            @(negedge clk);
            check("done_pulse", done, 0);
        end
    endtask

    task automatic watch_no_done(input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("no_done_or_busy", seen, 0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        #12;
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 32'hFFFFFFFD, 32'd7);
        check("mult_neg_hi", HI, 32'hFFFFFFFF);
        check("mult_neg_lo", LO, 32'hFFFFFFEB);
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_max_hi", HI, 32'hFFFFFFFE);
        run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2);
        check("div_trunc_lo", LO, 32'hFFFFFFFD);
        run_op(3'd3, 32'd7, 32'd0);
        check("divu_zero_lo", LO, 32'hFFFFFFFF);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_lo", LO, 32'h80000000);
        run_op(3'd2, 32'h80000005, 32'd0);

        // Second start while busy is ignored.
        @(negedge clk);
        start = 1'b1; op = 3'd1; srcA = 32'd5; srcB = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; op = 3'd3; srcA = 32'd9; srcB = 32'd2;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        check("ignore_done", done, 1);
        check("ignore_hi", HI, 0);
        check("ignore_lo", LO, 30);
        hi_m = 0; lo_m = 30;
        watch_no_done(40);

        // Flush mid-divide.
        @(negedge clk);
        start = 1'b1; op = 3'd3; srcA = 32'd100; srcB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", busy, 0);
        watch_no_done(40);
        check("flush_hi", HI, hi_m);
        check("flush_lo", LO, lo_m);

        // Flush with start in idle, and a reserved op.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd5; srcA = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", busy, 0);
        check("flush_start_lo", LO, lo_m);
        run_op(3'd6, 32'h55, 32'h66);

        run_op(3'd5, 32'h1234, 32'h0);
        // MTHI while busy is dropped.
        @(negedge clk);
        start = 1'b1; op = 3'd1; srcA = 32'd11; srcB = 32'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = 3'd4; srcA = 32'hBEEF;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        check("mthi_busy_hi", HI, 0);
        check("mthi_busy_lo", LO, 143);
        hi_m = 0; lo_m = 143;

        // Async reset mid-multiply.
        @(negedge clk);
        start = 1'b1; op = 3'd0; srcA = 32'h7FFFFFFF; srcB = 32'h7FFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", HI, 0);
        check("arst_lo", LO, 0);
        hi_m = 0; lo_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd0, 32'd2, 32'd3);

        for (int k = 0; k < 60; k++) begin
            ro = 3'($urandom_range(0, 6));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) - 32'd4 : $urandom;
            run_op(ro, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
